imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter NWORDS, default 1024, capacity of the target instruction memory in XLEN-bit words.
REQ-002 XLEN comes from constants.vh and is 32.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
REQ-006 in_valid  input  1  in_data holds a valid byte.
REQ-007 in_data  input  8  byte of the program stream.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 mem_we  output  1  one-cycle write strobe to the instruction memory write port.
REQ-010 mem_addr  output  XLEN  byte address of the write; word index shifted left by 2.
REQ-011 mem_wdata  output  XLEN  word to write.
REQ-012 busy  output  1  high in LEN, DATA and CHECK.
REQ-013 done  output  1  high in DONE.
REQ-014 err  output  1  high in ERR.

Function
REQ-015 A byte transfers only on a cycle where in_valid and in_ready are both high.
REQ-016 Stream format: 4-byte length N (word count), then N words, then a 4-byte checksum when CHECKSUM_EN is defined; every multi-byte field is little-endian.
REQ-017 States: IDLE, LEN, DATA, CHECK, DONE, ERR.
REQ-018 State transitions:
- IDLE/DONE/ERR + start -> LEN; this clears the byte counter, word index and checksum.
- LEN, after byte 3 -> ERR if N > NWORDS; else DATA if N > 0; else CHECK or DONE.
- DATA, after byte 3 of word N-1 -> CHECK or DONE.
- CHECK, after byte 3 -> DONE on a match, ERR on a mismatch.
REQ-019 in_ready is high exactly in LEN, DATA and CHECK; it is low in IDLE, DONE and ERR.
REQ-020 A 2-bit byte counter assembles each word; byte k lands in bits [8k+7:8k].
REQ-021 In DATA, accepting byte 3 of word i registers mem_we=1, mem_addr=i<<2 and mem_wdata=word for exactly the next cycle; that is a latency of 1 cycle.
REQ-022 mem_we is low on every other cycle, and mem_addr/mem_wdata hold their last value.
REQ-023 The loader never writes beyond word index N-1, so there are at most N writes per load.
REQ-024 start asserted in LEN, DATA or CHECK is ignored.
REQ-025 in_valid gaps stall the loader with no timeout; partial words are held.
REQ-026 The final write strobe and the entry into DONE occur on the same cycle.

Reset
REQ-027 While reset is high, the loader goes to IDLE and every output is 0 (in_ready, mem_we, mem_addr, mem_wdata, busy, done, err).
REQ-028 Reset mid-load aborts the load: no write strobe is issued after the reset edge, and words already written are not undone.
REQ-029 Reset has priority over start and over byte acceptance in the same cycle.

Configuration
REQ-030 Macro IMEM_LOADER_CHECKSUM_EN.
REQ-031 When IMEM_LOADER_CHECKSUM_EN is defined, a running XOR of all data words is kept. The CHECK state then compares that XOR against the trailing 4-byte field: a match goes to DONE, a mismatch goes to ERR. With N=0 the expected checksum is 0.
REQ-032 When IMEM_LOADER_CHECKSUM_EN is undefined, the CHECK state and the XOR register do not exist. The transition after the last word (or after N=0) goes straight to DONE, and err can assert only for N > NWORDS.

Verification
REQ-033 Load N=2, words 0x00000013 and 0x00100093, with in_valid held high -> writes at addr 0x0 and 0x4 with those values, each a 1-cycle mem_we; done=1; total of 2 strobes.
REQ-034 Same stream with in_valid toggling every other cycle -> identical writes; in_ready stays high throughout the load; no duplicate strobes.
REQ-035 N=NWORDS+1 -> err=1 after the 4th length byte; zero mem_we; in_ready=0.
REQ-036 N=0 -> no writes; done=1 (CHECKSUM_EN: after checksum 0x00000000; checksum 0x00000001 gives err=1).
REQ-037 CHECKSUM_EN, N=2 as in REQ-033, checksum 0x00100080 -> done=1; checksum 0x00100081 -> err=1, and both writes still occurred.
REQ-038 Reset asserted after 6 data bytes of a N=2 load -> next cycle all outputs 0 and state IDLE; no strobe for the partial word; a subsequent start and full stream loads correctly.

Source files
------------

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Loads a program image from a byte stream into an instruction
//               memory write port. Stream layout (all fields little-endian):
//                 4-byte word count N, N 32-bit words, and, when the macro
//                 IMEM_LOADER_CHECKSUM_EN is defined, a 4-byte XOR checksum
//                 of all data words.
// Optional    : `define IMEM_LOADER_CHECKSUM_EN adds the CHECK state and the
//               running XOR register; without it the load ends after the
//               last word (or after N=0).
// Ports       : clk, reset       - clock, synchronous active-high reset
//               start            - begin a load (IDLE/DONE/ERR only)
//               in_valid/in_data - byte stream input
//               in_ready         - byte accepted when in_valid is also high
//               mem_we/mem_addr/mem_wdata - 1-cycle write strobe, byte
//                                  address (word index << 2), word data
//               busy/done/err    - status (LEN/DATA/CHECK, DONE, ERR)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int NWORDS = 1024,
  localparam int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [XLEN-1:0] c_NWORDS = XLEN'(NWORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK = 3'd3,
`endif
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  state_t          w_after_data;
  logic [1:0]      r_cnt;
  logic [23:0]     r_buf;      // bytes 0..2 of the field being assembled
  logic [XLEN-1:0] r_len;
  logic [XLEN-1:0] r_widx;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [XLEN-1:0] r_xor;
`endif

  logic            w_loading;
  logic            w_accept;
  logic            w_last_byte;
  logic            w_last_word;
  logic            w_start_ok;
  logic [XLEN-1:0] w_full;

  assign w_loading   = (r_state == S_LEN) || (r_state == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                       || (r_state == S_CHECK)
`endif
                       ;
  // Reset gates the handshake so no byte is taken in a reset cycle.
  assign w_accept    = in_valid && w_loading && !reset;
  assign w_last_byte = (r_cnt == 2'd3);
  // The fourth byte goes straight from the input into the top lane.
  assign w_full      = {in_data, r_buf};
  assign w_last_word = (r_widx == (r_len - XLEN'(1)));
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                 (r_state == S_ERR));

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign w_after_data = S_CHECK;
`else
  assign w_after_data = S_DONE;
`endif

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_next = S_LEN;
      end
      S_LEN: begin
        if (w_accept && w_last_byte) begin
          if (w_full > c_NWORDS)         w_next = S_ERR;
          else if (w_full != '0)         w_next = S_DATA;
          else                           w_next = w_after_data;
        end
      end
      S_DATA: begin
        if (w_accept && w_last_byte && w_last_word) w_next = w_after_data;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (w_accept && w_last_byte)
          w_next = (w_full == r_xor) ? S_DONE : S_ERR;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_buf       <= '0;
      r_len       <= '0;
      r_widx      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_xor       <= '0;
`endif
    end else begin
      r_state  <= w_next;
      r_mem_we <= 1'b0;
      if (w_start_ok) begin
        r_cnt  <= 2'd0;
        r_widx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_xor  <= '0;
`endif
      end else if (w_accept) begin
        r_cnt <= r_cnt + 2'd1;
        case (r_cnt)
          2'd0:    r_buf[7:0]   <= in_data;
          2'd1:    r_buf[15:8]  <= in_data;
          2'd2:    r_buf[23:16] <= in_data;
          default: r_buf        <= r_buf;
        endcase
        if (w_last_byte && (r_state == S_LEN)) begin
          r_len <= w_full;
        end
        if (w_last_byte && (r_state == S_DATA)) begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= {r_widx[XLEN-3:0], 2'b00};
          r_mem_wdata <= w_full;
          r_widx      <= r_widx + XLEN'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          r_xor       <= r_xor ^ w_full;
`endif
        end
      end
    end
  end

  // Status outputs are forced low during reset, before the first reset edge
  // has settled the state register.
  assign in_ready  = w_loading && !reset;
  assign busy      = w_loading && !reset;
  assign done      = (r_state == S_DONE) && !reset;
  assign err       = (r_state == S_ERR) && !reset;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader. Covers both
//               builds (IMEM_LOADER_CHECKSUM_EN defined or not).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int nwr    = 0;
  int stalls = 0;
  int ready_drop = 0;
  logic [31:0] wa [0:7];
  logic [31:0] wd [0:7];

  imem_loader #(.NWORDS(1024)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (nwr < 8) begin
        wa[nwr] = mem_addr;
        wd[nwr] = mem_wdata;
      end
      nwr = nwr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    while (!in_ready && t < 16) begin
      @(negedge clk);
      t++;
    end
    if (t != 0) ready_drop++;
    if (!in_ready) begin
      stalls++;
      in_valid = 1'b0;
    end else begin
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      if (gap) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    logic [31:0] v = w;
    for (int k = 0; k < 4; k++) send_byte(v[8*k +: 8], gap);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"},   nwr,   32'd2);
    check({tag, "_addr0"}, wa[0], 32'h0000_0000);
    check({tag, "_data0"}, wd[0], 32'h0000_0013);
    check({tag, "_addr1"}, wa[1], 32'h0000_0004);
    check({tag, "_data1"}, wd[1], 32'h0010_0093);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_we",    {31'd0, mem_we},   32'd0);
    check("rst_addr",  mem_addr,          32'd0);
    check("rst_wdata", mem_wdata,         32'd0);
    check("rst_status", {29'd0, busy, done, err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'd0, in_ready}, 32'd0);

    // Load A, in_valid held high; start mid-load must be ignored.
    nwr = 0;
    do_start();
    check("len_busy", {31'd0, busy}, 32'd1);
    send_word(32'd2, 1'b0);
    start = 1'b1;
    send_byte(8'h13, 1'b0);
    start = 1'b0;
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_word(32'h0010_0093, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'h0010_0080, 1'b0);
    in_valid = 1'b0;
`else
    in_valid = 1'b0;
    check("A_last_we_with_done", {30'd0, mem_we, done}, 32'd3);
    @(negedge clk);
    check("A_we_one_cycle", {31'd0, mem_we}, 32'd0);
    check("A_addr_hold", mem_addr, 32'h4);
`endif
    check_writes("A");
    check("A_status", {29'd0, busy, done, err}, 32'b010);
    check("A_ready_low", {31'd0, in_ready}, 32'd0);

    // Load B, in_valid toggling every other cycle.
    nwr = 0; ready_drop = 0;
    do_start();
    send_word(32'd2, 1'b1);
    send_word(32'h0000_0013, 1'b1);
    send_word(32'h0010_0093, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'h0010_0080, 1'b1);
`endif
    repeat (2) @(negedge clk);
    check_writes("B");
    check("B_ready_drop", ready_drop, 32'd0);
    check("B_done", {31'd0, done}, 32'd1);

    // Oversized length.
    nwr = 0;
    do_start();
    send_word(32'd1025, 1'b0);
    in_valid = 1'b0;
    check("ovf_err", {29'd0, busy, done, err}, 32'b001);
    check("ovf_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    check("ovf_nwr", nwr, 32'd0);

    // Empty program.
    nwr = 0;
    do_start();
    send_word(32'd0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("n0_wait_check", {29'd0, busy, done, err}, 32'b100);
    send_word(32'd0, 1'b0);
`endif
    in_valid = 1'b0;
    check("n0_done", {29'd0, busy, done, err}, 32'b010);
    check("n0_nwr", nwr, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_start();
    send_word(32'd0, 1'b0);
    send_word(32'd1, 1'b0);
    in_valid = 1'b0;
    check("n0_bad_sum", {29'd0, busy, done, err}, 32'b001);

    nwr = 0;
    do_start();
    send_word(32'd2, 1'b0);
    send_word(32'h0000_0013, 1'b0);
    send_word(32'h0010_0093, 1'b0);
    send_word(32'h0010_0081, 1'b0);
    in_valid = 1'b0;
    check("bad_sum_err", {29'd0, busy, done, err}, 32'b001);
    check_writes("bad_sum");
`endif

    // Reset after 6 data bytes of an N=2 load, with start and a byte pending.
    nwr = 0;
    do_start();
    send_word(32'd2, 1'b0);
    send_word(32'h0000_0013, 1'b0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b0);
    reset = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'hAB;
    @(negedge clk);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_we",    {31'd0, mem_we},   32'd0);
    check("mid_rst_addr",  mem_addr,          32'd0);
    check("mid_rst_wdata", mem_wdata,         32'd0);
    check("mid_rst_status", {29'd0, busy, done, err}, 32'd0);
    check("mid_rst_nwr", nwr, 32'd1);
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_nwr", nwr, 32'd1);
    check("post_rst_idle", {29'd0, busy, done, err}, 32'd0);

    nwr = 0;
    do_start();
    send_word(32'd2, 1'b0);
    send_word(32'h0000_0013, 1'b0);
    send_word(32'h0010_0093, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'h0010_0080, 1'b0);
`endif
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_writes("reload");
    check("reload_done", {31'd0, done}, 32'd1);
    check("no_stalls", stalls, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
